// File: rtl/adc_sample_averager.sv
// Block averager for ADC121S101 frames: extracts the sample field, averages 2^AVG_LOG2 samples,
// presents the mean on a valid/ready port. Optional min/max tracking under `ADC_MINMAX_EN.
module adc_sample_averager #(
    parameter int SAMPLE_W   = 12,
    parameter int SAMPLE_LSB = 1,
    parameter int AVG_LOG2   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                in_valid,
    input  logic [15:0]         in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_avg,
    output logic                overrun,
    input  logic                clr_overrun,
    output logic [SAMPLE_W-1:0] out_min,
    output logic [SAMPLE_W-1:0] out_max
);

    localparam int ACC_W = SAMPLE_W + AVG_LOG2;
    // A zero-width counter is illegal; with AVG_LOG2=0 the 1-bit count simply stays at 0.
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t              state, state_next;
    logic [ACC_W-1:0]    acc, acc_next, sum;
    logic [CNT_W-1:0]    count, count_next;
    logic [SAMPLE_W-1:0] sample, mean;
    logic                take, block_done, out_load, out_drop;
    logic                unused_frame_bits;

    assign sample            = in_data[SAMPLE_LSB +: SAMPLE_W];
    assign unused_frame_bits = ^in_data;
    assign sum               = acc + ACC_W'(sample);
    assign mean              = SAMPLE_W'(sum >> AVG_LOG2);

    always_comb begin
        state_next = state;
        acc_next   = acc;
        count_next = count;
        take       = 1'b0;
        block_done = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = ACCUM;
                    take       = in_valid;
                end
            end
            ACCUM: begin
                if (!enable) begin
                    state_next = IDLE;
                    acc_next   = '0;
                    count_next = '0;
                end else begin
                    take = in_valid;
                end
            end
            default: state_next = IDLE;
        endcase
        if (take) begin
            if (count == CNT_LAST) begin
                block_done = 1'b1;
                acc_next   = '0;
                count_next = '0;
            end else begin
                acc_next   = sum;
                count_next = count + CNT_W'(1);
            end
        end
    end

    // A finished block is only dropped when the previous result is still unaccepted.
    assign out_load = block_done && (!out_valid || out_ready);
    assign out_drop = block_done && out_valid && !out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_avg   <= '0;
            overrun   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            count <= count_next;
            if (out_load) begin
                out_valid <= 1'b1;
                out_avg   <= mean;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_drop)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

`ifdef ADC_MINMAX_EN
    logic [SAMPLE_W-1:0] run_min, run_max, blk_min, blk_max;
    logic                first;

    // count==0 marks the first sample of a block, so stale extremes from a discarded block never leak.
    always_comb begin
        first   = (count == '0);
        blk_min = (first || sample < run_min) ? sample : run_min;
        blk_max = (first || sample > run_max) ? sample : run_max;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_min <= '0;
            run_max <= '0;
            out_min <= '0;
            out_max <= '0;
        end else begin
            if (take) begin
                run_min <= blk_min;
                run_max <= blk_max;
            end
            if (out_load) begin
                out_min <= blk_min;
                out_max <= blk_max;
            end
        end
    end
`else
    assign out_min = '0;
    assign out_max = '0;
`endif

endmodule

// File: tb/tb_adc_sample_averager.sv
// Scoreboard bench for adc_sample_averager (default parameters); define ADC_MINMAX_EN to check min/max.
module tb_adc_sample_averager;

    logic        clk = 1'b0;
    logic        reset, enable, in_valid, out_ready, clr_overrun;
    logic [15:0] in_data;
    logic        out_valid, overrun;
    logic [11:0] out_avg, out_min, out_max;

    adc_sample_averager dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_avg(out_avg), .overrun(overrun),
        .clr_overrun(clr_overrun), .out_min(out_min), .out_max(out_max)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] avg;
        logic [11:0] mn;
        logic [11:0] mx;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        got_e;
    int          checks = 0;
    int          passed = 0;
    logic [11:0] blk[16];

    // Handshakes are visible at the negedge because inputs only change just after posedge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got avg=%0d min=%0d max=%0d, want no output", out_avg, out_min, out_max);
            end else begin
                got_e = exp_q.pop_front();
                if (out_avg !== got_e.avg || out_min !== got_e.mn || out_max !== got_e.mx)
                    $display("FAIL sb_result: got avg=%0d min=%0d max=%0d, want avg=%0d min=%0d max=%0d",
                             out_avg, out_min, out_max, got_e.avg, got_e.mn, got_e.mx);
                else
                    passed++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    function automatic logic [15:0] frame(input logic [11:0] s);
        logic [15:0] f;
        f       = 16'($urandom);
        f[12:1] = s;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] s);
        in_valid = 1'b1;
        in_data  = frame(s);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [11:0] s[16]);
        exp_t        x;
        int          total;
        logic [11:0] mn, mx;
        total = 0;
        mn    = s[0];
        mx    = s[0];
        for (int i = 0; i < 16; i++) begin
            total += int'(s[i]);
            if (s[i] < mn) mn = s[i];
            if (s[i] > mx) mx = s[i];
        end
        x.avg = 12'(total >> 4);
`ifdef ADC_MINMAX_EN
        x.mn = mn;
        x.mx = mx;
`else
        x.mn = '0;
        x.mx = '0;
`endif
        exp_q.push_back(x);
    endtask

    task automatic run_block(input logic [11:0] s[16], input bit expect_out);
        if (expect_out) push_exp(s);
        for (int i = 0; i < 16; i++) send(s[i]);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; in_valid = 1'b1; in_data = frame(12'd77);
        repeat (3) tick();
        checks++;
        if ({out_valid, out_avg, overrun, out_min, out_max} !== '0)
            $display("FAIL reset_values: got valid=%0b avg=%0d ovr=%0b min=%0d max=%0d, want all 0",
                     out_valid, out_avg, overrun, out_min, out_max);
        else passed++;
        in_valid = 1'b0; enable = 1'b0; reset = 1'b0;
        repeat (2) tick();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_idle: got valid=%0b, want 0", out_valid);
        else passed++;
    endtask

    task automatic test_basic();
        enable = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) blk[i] = 12'(100 + i);
        run_block(blk, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_avg !== 12'd107)
            $display("FAIL basic_latency: got valid=%0b avg=%0d, want valid=1 avg=107", out_valid, out_avg);
        else passed++;
        tick();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL basic_pulse: got valid=%0b, want 0", out_valid);
        else passed++;
    endtask

    task automatic test_extremes();
        foreach (blk[i]) blk[i] = 12'hFFF;
        run_block(blk, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_avg !== 12'hFFF)
            $display("FAIL full_scale: got valid=%0b avg=%0h, want valid=1 avg=fff", out_valid, out_avg);
        else passed++;
        tick();
        foreach (blk[i]) blk[i] = 12'd1;
        blk[15] = 12'd2;
        run_block(blk, 1'b1);
        checks++;
        if (out_avg !== 12'd1) $display("FAIL floor: got avg=%0d, want 1", out_avg);
        else passed++;
        tick();
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        foreach (blk[i]) blk[i] = 12'd10;
        run_block(blk, 1'b1);
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b1 || out_avg !== 12'd10 || overrun !== 1'b0)
            $display("FAIL hold: got valid=%0b avg=%0d ovr=%0b, want valid=1 avg=10 ovr=0", out_valid, out_avg, overrun);
        else passed++;
        foreach (blk[i]) blk[i] = 12'd20;
        run_block(blk, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_avg !== 12'd10 || overrun !== 1'b1)
            $display("FAIL drop: got valid=%0b avg=%0d ovr=%0b, want valid=1 avg=10 ovr=1", out_valid, out_avg, overrun);
        else passed++;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || overrun !== 1'b1)
            $display("FAIL accept_sticky: got valid=%0b ovr=%0b, want valid=0 ovr=1", out_valid, overrun);
        else passed++;
        clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b0) $display("FAIL clr_overrun: got ovr=%0b, want 0", overrun);
        else passed++;
        // set and clear on the same cycle: set must win
        out_ready = 1'b0;
        foreach (blk[i]) blk[i] = 12'd11;
        run_block(blk, 1'b1);
        for (int i = 0; i < 15; i++) send(12'd12);
        clr_overrun = 1'b1;
        send(12'd12);
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b1 || out_avg !== 12'd11)
            $display("FAIL set_wins: got ovr=%0b avg=%0d, want ovr=1 avg=11", overrun, out_avg);
        else passed++;
        out_ready = 1'b1; tick();
        clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        foreach (blk[i]) blk[i] = 12'd25;
        run_block(blk, 1'b1);
        foreach (blk[i]) blk[i] = 12'd30;
        push_exp(blk);
        for (int i = 0; i < 15; i++) send(12'd30);
        out_ready = 1'b1;
        send(12'd30);
        checks++;
        if (out_valid !== 1'b1 || out_avg !== 12'd30 || overrun !== 1'b0)
            $display("FAIL back_to_back: got valid=%0b avg=%0d ovr=%0b, want valid=1 avg=30 ovr=0", out_valid, out_avg, overrun);
        else passed++;
        tick();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL b2b_release: got valid=%0b, want 0", out_valid);
        else passed++;
    endtask

    task automatic test_enable_drop();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(12'd7);
        enable = 1'b0; in_valid = 1'b1; in_data = frame(12'd999);
        tick();
        in_valid = 1'b0; enable = 1'b1;
        foreach (blk[i]) blk[i] = 12'd50;
        run_block(blk, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_avg !== 12'd50)
            $display("FAIL enable_drop: got valid=%0b avg=%0d, want valid=1 avg=50", out_valid, out_avg);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        foreach (blk[i]) blk[i] = 12'd60;
        run_block(blk, 1'b0);
        foreach (blk[i]) blk[i] = 12'd61;
        run_block(blk, 1'b0);
        for (int i = 0; i < 8; i++) send(12'd9);
        reset = 1'b1; in_valid = 1'b1; in_data = frame(12'd400);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_avg, overrun, out_min, out_max} !== '0)
            $display("FAIL reset_mid: got valid=%0b avg=%0d ovr=%0b min=%0d max=%0d, want all 0",
                     out_valid, out_avg, overrun, out_min, out_max);
        else passed++;
        reset = 1'b0; tick();
        out_ready = 1'b1;
        foreach (blk[i]) blk[i] = 12'd50;
        run_block(blk, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_avg !== 12'd50)
            $display("FAIL after_reset: got valid=%0b avg=%0d, want valid=1 avg=50", out_valid, out_avg);
        else passed++;
        tick();
    endtask

    task automatic test_minmax();
        logic [11:0] want_mn, want_mx;
        out_ready = 1'b1;
        blk = '{12'd5, 12'd900, 12'd3, 12'd40, 12'd17, 12'd250, 12'd600, 12'd88,
                12'd12, 12'd7, 12'd400, 12'd33, 12'd64, 12'd128, 12'd256, 12'd512};
        run_block(blk, 1'b1);
`ifdef ADC_MINMAX_EN
        want_mn = 12'd3; want_mx = 12'd900;
`else
        want_mn = 12'd0; want_mx = 12'd0;
`endif
        checks++;
        if (out_min !== want_mn || out_max !== want_mx)
            $display("FAIL minmax: got min=%0d max=%0d, want min=%0d max=%0d", out_min, out_max, want_mn, want_mx);
        else passed++;
        tick();
        for (int i = 0; i < 16; i++) blk[i] = 12'(515 - i);
        run_block(blk, 1'b1);
`ifdef ADC_MINMAX_EN
        want_mn = 12'd500; want_mx = 12'd515;
`endif
        checks++;
        if (out_min !== want_mn || out_max !== want_mx)
            $display("FAIL minmax_reseed: got min=%0d max=%0d, want min=%0d max=%0d", out_min, out_max, want_mn, want_mx);
        else passed++;
        tick();
    endtask

    task automatic test_drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) $display("FAIL sb_drain: got %0d results outstanding, want 0", exp_q.size());
        else passed++;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; clr_overrun = 1'b0;
        test_reset();
        test_basic();
        test_extremes();
        test_overrun();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_minmax();
        test_drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
